hazard_scoreboard: RTL
======================

# hazard_scoreboard

Tracks every in-flight register write in the pipelined CPU with a per-register countdown, and generates the stall, bubble and flush controls that the forwarding unit cannot resolve. Covered cases: load-use, jump-register resolved in ID, long-latency multiply/divide results, and write-after-write ordering. Sits beside the ID stage; it drives PC/IF-ID write enables and ID/EX bubble insertion, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 3, width of each per-register countdown
- LOAD_LAT, 2, countdown loaded when a load issues
- ALU_LAT, 1, countdown loaded when an ALU/other writer issues
- MD_LAT, 5, countdown loaded when a multiply/divide issues; must be < 2^CNT_W

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  source register A of the ID instruction
- id_rt  in  5  source register B of the ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_is_jr  in  1  ID instruction is JR/JALR; rs is consumed in ID
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  5  destination register of the ID instruction
- id_is_load  in  1  ID instruction is a load
- id_is_md  in  1  ID instruction is multiply/divide
- ex_flush  in  1  taken branch/jump resolved in EX; kill IF/ID
- pc_write  out  1  1 = PC may advance
- ifid_write  out  1  1 = IF/ID register may load
- idex_bubble  out  1  1 = load a NOP into ID/EX this cycle
- ifid_flush  out  1  1 = clear IF/ID this cycle
- stall_cycles  out  32  count of cycles with a stall asserted

## Operation
- State: cnt[1..31], each CNT_W bits. Register 0 has no entry and always reads 0. Also holds stall_cycles.
- Every cycle, each nonzero cnt decrements by 1, saturating at 0.
- Stall conditions. All are gated by id_valid and use the current, pre-decrement cnt:
  - rs_haz = id_use_rs & !id_is_jr & cnt[id_rs] >= 2
  - jr_haz = id_is_jr & cnt[id_rs] >= 1
  - rt_haz = id_use_rt & cnt[id_rt] >= 2
  - waw_haz = id_wr_en & id_wr_addr != 0 & cnt[id_wr_addr] > new_lat
  - stall = rs_haz | rt_haz | jr_haz | waw_haz
- new_lat: MD_LAT if id_is_md, else LOAD_LAT if id_is_load, else ALU_LAT. id_is_md takes precedence over id_is_load.
- Issue: id_valid & !stall & !ex_flush. On issue with id_wr_en and id_wr_addr != 0, cnt[id_wr_addr] <= new_lat. This overrides the decrement for that entry in the same cycle.
- Outputs:
  - ex_flush=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, and no issue. Flush has priority over stall.
  - Else stall=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Else: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- stall_cycles increments when stall & !ex_flush. It wraps from 0xFFFFFFFF to 0.
- Outputs are combinational from registered state plus ID inputs. No combinational path exists from outputs back to inputs.

## Timing
- Reset, asynchronous: all cnt=0 and stall_cycles=0. With id_valid=0 the outputs are pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- A load issued in cycle t:
  - A dependent in ID at t+1 sees cnt=2 and stalls 1 cycle.
  - At t+2 it sees cnt=1 and proceeds; MEM/WB forwarding covers it.
- An ALU writer issued in cycle t:
  - A dependent JR at t+1 sees cnt=1 and stalls 1 cycle.
  - A normal dependent at t+1 does not stall.
- An MD writer issued at t: a normal dependent stalls until cnt <= 1, i.e. MD_LAT-1 cycles.
- Stall persists while the condition holds. The ID instruction must stay constant while stalled because ifid_write=0.
- Reset asserted mid-stall clears all stall state immediately, without waiting for a clock edge.
- A simultaneous issue-write and decrement on one entry resolves to new_lat.
- A self-dependency (rs == wr_addr) is evaluated against the old cnt.

## Test plan
- Load to r8, then a consumer of r8 as rs in the next cycle: exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1. Then the consumer issues.
- ALU write to r31, then `jr r31` next: 1 stall cycle. With one independent instruction in between: 0 stalls.
- MD to r4 with MD_LAT=5, then a consumer of r4 as rt: 4 stall cycles; stall_cycles=4.
- MD to r4, then an ALU write to r4 (WAW): the ALU stalls until cnt[r4] <= 1, then issues and cnt[r4]=1.
- Load to r8 and ex_flush=1 in the same cycle: ifid_flush=1, idex_bubble=1, pc_write=1, no issue, so cnt[r8] stays 0. A load to r0 followed by a consumer of r0: no stall.
- Reset asserted mid-MD-stall: outputs return to their reset values asynchronously and all counters read 0. Also preload stall_cycles to 0xFFFFFFFF; one stall cycle wraps it to 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query and pipeline control bundle between the decoder and the scoreboard.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_jr;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_load;
  logic        id_is_md;
  logic        ex_flush;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [31:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_jr,
           id_wr_en, id_wr_addr, id_is_load, id_is_md, ex_flush,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_jr,
           id_wr_en, id_wr_addr, id_is_load, id_is_md, ex_flush,
    output pc_write, ifid_write, idex_bubble, ifid_flush, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register write-latency countdowns; produces stall/bubble/flush controls for the ID stage
// and a free-running stall cycle counter.
module hazard_scoreboard #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned MD_LAT   = 5
) (
  input  logic           clk,
  input  logic           reset,
  hazard_scoreboard_if.slave hs
);

  typedef logic [CNT_W-1:0] cnt_t;

  if (MD_LAT >= (1 << CNT_W)) begin : g_md_lat_check
    $error("MD_LAT does not fit in CNT_W bits");
  end

  cnt_t        cnt_q [1:31];
  cnt_t        cnt_d [1:31];
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  cnt_t rs_cnt;
  cnt_t rt_cnt;
  cnt_t wa_cnt;
  cnt_t new_lat;
  logic rs_haz;
  logic rt_haz;
  logic jr_haz;
  logic waw_haz;
  logic stall;
  logic issue;

  // Register 0 has no entry, so every lookup defaults to zero.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    wa_cnt = '0;
    for (int i = 1; i < 32; i++) begin
      if (hs.id_rs == 5'(i))      rs_cnt = cnt_q[i];
      if (hs.id_rt == 5'(i))      rt_cnt = cnt_q[i];
      if (hs.id_wr_addr == 5'(i)) wa_cnt = cnt_q[i];
    end
  end

  always_comb begin
    new_lat = cnt_t'(ALU_LAT);
    if (hs.id_is_md) begin
      new_lat = cnt_t'(MD_LAT);
    end else if (hs.id_is_load) begin
      new_lat = cnt_t'(LOAD_LAT);
    end
  end

  // Normal operands tolerate cnt==1 via forwarding; JR reads rs in ID so it cannot.
  always_comb begin
    rs_haz  = hs.id_use_rs & ~hs.id_is_jr & (rs_cnt >= cnt_t'(2));
    jr_haz  = hs.id_is_jr & (rs_cnt >= cnt_t'(1));
    rt_haz  = hs.id_use_rt & (rt_cnt >= cnt_t'(2));
    waw_haz = hs.id_wr_en & (hs.id_wr_addr != 5'd0) & (wa_cnt > new_lat);
    stall   = hs.id_valid & (rs_haz | rt_haz | jr_haz | waw_haz);
    issue   = hs.id_valid & ~stall & ~hs.ex_flush;
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - cnt_t'(1) : '0;
      if (issue && hs.id_wr_en && (hs.id_wr_addr == 5'(i))) begin
        cnt_d[i] = new_lat;
      end
    end
    stall_cycles_d = stall_cycles_q + 32'(stall & ~hs.ex_flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Flush wins over stall: the stalled ID instruction is being killed anyway.
  always_comb begin
    hs.pc_write    = 1'b1;
    hs.ifid_write  = 1'b1;
    hs.idex_bubble = 1'b0;
    hs.ifid_flush  = 1'b0;
    if (hs.ex_flush) begin
      hs.idex_bubble = 1'b1;
      hs.ifid_flush  = 1'b1;
    end else if (stall) begin
      hs.pc_write    = 1'b0;
      hs.ifid_write  = 1'b0;
      hs.idex_bubble = 1'b1;
    end
  end

  assign hs.stall_cycles = stall_cycles_q;

endmodule
